// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit-port arbiter.
package uart_arb_pkg;

  localparam int unsigned BYTE_W          = 8;
  localparam int unsigned DEFAULT_TIMEOUT = 1_000_000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    HOLD = 2'd2
  } arb_state_t;

  // Byte captured from the granted lane, plus its end-of-packet mark
  typedef struct packed {
    logic [BYTE_W-1:0] data;
    logic              last;
  } tx_beat_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  int pos;

  // Wrap with an explicit compare so non-power-of-two N never indexes past N-1
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = 0;
    for (int k = 0; k < int'(N); k++) begin
      pos = int'(ptr) + k;
      if (pos >= int'(N)) pos = pos - int'(N);
      if (!any && req[IW'(pos)]) begin
        any               = 1'b1;
        idx               = IW'(pos);
        grant[IW'(pos)]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin sharing of one UART transmitter byte port
// among N requesters, with an idle timeout that breaks a stalled packet lock.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   cpu_resetn,
  input  logic [N-1:0]           req_valid_i,
  input  logic [BYTE_W*N-1:0]    req_data_i,
  input  logic [N-1:0]           req_last_i,
  output logic [N-1:0]           req_ready_o,
  output logic [BYTE_W-1:0]      tx_data_o,
  output logic                   tx_ready_o,
  input  logic                   tx_ack_i,
  output logic [$clog2(N)-1:0]   grant_o,
  output logic                   busy_o,
  output logic                   timeout_o
);

  localparam int unsigned IW = $clog2(N);
  localparam int unsigned TW = $clog2(TIMEOUT);

  arb_state_t        state, state_n;
  tx_beat_t          beat, beat_n;
  logic [IW-1:0]     rr_ptr, rr_ptr_n;
  logic [IW-1:0]     grant_n;
  logic [IW-1:0]     next_ptr;
  logic [TW-1:0]     timer, timer_n;
  logic              tx_ready_n, busy_n, timeout_n;

  logic [N-1:0]      pick_onehot;
  logic [IW-1:0]     pick_idx;
  logic              pick_any;
  logic [BYTE_W-1:0] lane [N];

  for (genvar g = 0; g < int'(N); g++) begin : g_lane
    assign lane[g] = req_data_i[BYTE_W*g +: BYTE_W];
  end

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req   (req_valid_i),
    .ptr   (rr_ptr),
    .grant (pick_onehot),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign next_ptr  = (grant_o == IW'(N - 1)) ? '0 : grant_o + IW'(1);
  assign tx_data_o = beat.data;

  always_comb begin
    state_n     = state;
    beat_n      = beat;
    rr_ptr_n    = rr_ptr;
    grant_n     = grant_o;
    timer_n     = timer;
    tx_ready_n  = tx_ready_o;
    timeout_n   = 1'b0;
    req_ready_o = '0;
    case (state)
      IDLE: begin
        req_ready_o = pick_onehot;
        if (pick_any) begin
          beat_n.data = lane[pick_idx];
          beat_n.last = req_last_i[pick_idx];
          grant_n     = pick_idx;
          tx_ready_n  = 1'b1;
          state_n     = SEND;
        end
      end
      SEND: begin
        if (tx_ack_i) begin
          tx_ready_n = 1'b0;
          timer_n    = '0;
          if (beat.last) begin
            state_n  = IDLE;
            rr_ptr_n = next_ptr;
          end else begin
            state_n  = HOLD;
          end
        end
      end
      HOLD: begin
        // Only the owner may continue; an accept on the expiry cycle wins
        req_ready_o[grant_o] = req_valid_i[grant_o];
        if (req_valid_i[grant_o]) begin
          beat_n.data = lane[grant_o];
          beat_n.last = req_last_i[grant_o];
          tx_ready_n  = 1'b1;
          timer_n     = '0;
          state_n     = SEND;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          timer_n   = '0;
          timeout_n = 1'b1;
          rr_ptr_n  = next_ptr;
          state_n   = IDLE;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      state      <= IDLE;
      beat       <= '0;
      rr_ptr     <= '0;
      grant_o    <= '0;
      timer      <= '0;
      tx_ready_o <= 1'b0;
      busy_o     <= 1'b0;
      timeout_o  <= 1'b0;
    end else begin
      state      <= state_n;
      beat       <= beat_n;
      rr_ptr     <= rr_ptr_n;
      grant_o    <= grant_n;
      timer      <= timer_n;
      tx_ready_o <= tx_ready_n;
      busy_o     <= busy_n;
      timeout_o  <= timeout_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: vector table plus multi-cycle sequences.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        cpu_resetn = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_last = '0;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        tx_ack = 1'b0;
  logic [1:0]  grant;
  logic        busy;
  logic        timeout;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_arbiter #(.N(4), .TIMEOUT(16)) dut (
    .clk         (clk),
    .cpu_resetn  (cpu_resetn),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_last_i  (req_last),
    .req_ready_o (req_ready),
    .tx_data_o   (tx_data),
    .tx_ready_o  (tx_ready),
    .tx_ack_i    (tx_ack),
    .grant_o     (grant),
    .busy_o      (busy),
    .timeout_o   (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic [3:0]  last;
    logic        ack;
    logic [3:0]  ready;
    logic        txr;
    logic [7:0]  txd;
    logic [1:0]  grant;
    logic        busy;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid  = '0;
    req_data   = '0;
    req_last   = '0;
    tx_ack     = 1'b0;
    cpu_resetn = 1'b0;
    tick();
    tick();
    cpu_resetn = 1'b1;
  endtask

  task automatic wait_tx(input string name);
    int cnt = 0;
    while (!tx_ready && cnt < 20) begin
      tick();
      cnt++;
    end
    chk(name, 32'(tx_ready), 32'd1);
  endtask

  task automatic ack_now();
    tx_ack = 1'b1;
    tick();
    tx_ack = 1'b0;
  endtask

  initial begin
    // valid, data, last, ack | ready, txr, txd, grant, busy
    vecs[0]  = '{4'b0001, 32'h0000_0041, 4'b0001, 1'b0, 4'b0001, 1'b0, 8'h00, 2'd0, 1'b0};
    vecs[1]  = '{4'b0000, 32'h0000_0041, 4'b0001, 1'b0, 4'b0000, 1'b1, 8'h41, 2'd0, 1'b1};
    vecs[2]  = '{4'b0000, 32'h0000_0041, 4'b0001, 1'b1, 4'b0000, 1'b1, 8'h41, 2'd0, 1'b1};
    vecs[3]  = '{4'b0000, 32'h0000_0041, 4'b0001, 1'b0, 4'b0000, 1'b0, 8'h41, 2'd0, 1'b0};
    vecs[4]  = '{4'b0000, 32'h0000_0041, 4'b0001, 1'b1, 4'b0000, 1'b0, 8'h41, 2'd0, 1'b0};
    vecs[5]  = '{4'b0011, 32'h0000_5150, 4'b0011, 1'b0, 4'b0010, 1'b0, 8'h41, 2'd0, 1'b0};
    vecs[6]  = '{4'b0011, 32'h0000_5150, 4'b0011, 1'b0, 4'b0000, 1'b1, 8'h51, 2'd1, 1'b1};
    vecs[7]  = '{4'b0011, 32'h0000_5150, 4'b0011, 1'b1, 4'b0000, 1'b1, 8'h51, 2'd1, 1'b1};
    vecs[8]  = '{4'b0011, 32'h0000_5150, 4'b0011, 1'b0, 4'b0001, 1'b0, 8'h51, 2'd1, 1'b0};
    vecs[9]  = '{4'b0000, 32'h0000_5150, 4'b0011, 1'b1, 4'b0000, 1'b1, 8'h50, 2'd0, 1'b1};
    vecs[10] = '{4'b0000, 32'h0000_5150, 4'b0011, 1'b0, 4'b0000, 1'b0, 8'h50, 2'd0, 1'b0};

    do_reset();
    #1;
    chk("rst_tx_ready", 32'(tx_ready), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);

    // Single byte, spurious ack in IDLE, rotation of the round-robin pointer
    for (int i = 0; i < 11; i++) begin
      req_valid = vecs[i].valid;
      req_data  = vecs[i].data;
      req_last  = vecs[i].last;
      tx_ack    = vecs[i].ack;
      #1;
      chk($sformatf("vec%0d_ready", i), 32'(req_ready), 32'(vecs[i].ready));
      chk($sformatf("vec%0d_txr", i), 32'(tx_ready), 32'(vecs[i].txr));
      chk($sformatf("vec%0d_txd", i), 32'(tx_data), 32'(vecs[i].txd));
      chk($sformatf("vec%0d_grant", i), 32'(grant), 32'(vecs[i].grant));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
      chk($sformatf("vec%0d_timeout", i), 32'(timeout), 32'd0);
      tick();
    end
    tx_ack = 1'b0;

    // Contention: all lanes valid with single-byte packets -> 0,1,2,3,0
    do_reset();
    req_valid = 4'hF;
    req_data  = 32'hA3A2_A1A0;
    req_last  = 4'hF;
    for (int n = 0; n < 5; n++) begin
      wait_tx($sformatf("cont%0d_wait", n));
      chk($sformatf("cont%0d_grant", n), 32'(grant), 32'(n % 4));
      chk($sformatf("cont%0d_data", n), 32'(tx_data), 32'(8'hA0 + 8'(n % 4)));
      chk($sformatf("cont%0d_ready_send", n), 32'(req_ready), 32'd0);
      tick();
      tick();
      ack_now();
      chk($sformatf("cont%0d_txr_low", n), 32'(tx_ready), 32'd0);
    end

    // Packet lock: lane 2 keeps the port for 3 bytes while lane 0 waits
    do_reset();
    req_valid = 4'b0100;
    req_data  = 32'h0010_00EE;
    req_last  = 4'b0001;
    #1;
    chk("lock_first_ready", 32'(req_ready), 32'b0100);
    tick();
    req_valid = 4'b0101;
    for (int b = 0; b < 3; b++) begin
      if (b > 0) begin
        req_data[23:16] = 8'(16 + b);
        req_last[2]     = (b == 2);
        #1;
        chk($sformatf("lock%0d_hold_ready", b), 32'(req_ready), 32'b0100);
        tick();
      end
      chk($sformatf("lock%0d_txr", b), 32'(tx_ready), 32'd1);
      chk($sformatf("lock%0d_data", b), 32'(tx_data), 32'(16 + b));
      chk($sformatf("lock%0d_grant", b), 32'(grant), 32'd2);
      chk($sformatf("lock%0d_ready_send", b), 32'(req_ready), 32'd0);
      ack_now();
    end
    req_valid = 4'b0001;
    #1;
    chk("lock_release_ready", 32'(req_ready), 32'b0001);
    tick();
    chk("lock_lane0_data", 32'(tx_data), 32'hEE);
    chk("lock_lane0_grant", 32'(grant), 32'd0);

    // Timeout: lane 1 stalls mid-packet, released after 16 HOLD cycles
    do_reset();
    req_valid = 4'b0010;
    req_data  = 32'h3300_7700;
    req_last  = 4'b1000;
    #1;
    chk("to_first_ready", 32'(req_ready), 32'b0010);
    tick();
    req_valid = 4'b1000;
    chk("to_first_data", 32'(tx_data), 32'h77);
    ack_now();
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk($sformatf("to_pulse_k%0d", k), 32'(timeout), 32'(k == 16));
      chk($sformatf("to_ready_k%0d", k), 32'(req_ready), (k == 16) ? 32'b1000 : 32'd0);
    end
    chk("to_busy_idle", 32'(busy), 32'd0);
    tick();
    chk("to_pulse_gone", 32'(timeout), 32'd0);
    chk("to_lane3_data", 32'(tx_data), 32'h33);
    chk("to_lane3_grant", 32'(grant), 32'd3);
    chk("to_lane3_txr", 32'(tx_ready), 32'd1);

    // Accept on the expiry cycle beats the timeout
    do_reset();
    req_valid = 4'b0010;
    req_data  = 32'h0000_7800;
    req_last  = 4'b0000;
    tick();
    req_valid = 4'b0000;
    ack_now();
    for (int k = 0; k < 15; k++) tick();
    chk("race_no_pulse_yet", 32'(timeout), 32'd0);
    req_valid = 4'b0010;
    req_data  = 32'h0000_7900;
    req_last  = 4'b0010;
    #1;
    chk("race_ready", 32'(req_ready), 32'b0010);
    tick();
    req_valid = 4'b0000;
    chk("race_timeout", 32'(timeout), 32'd0);
    chk("race_txr", 32'(tx_ready), 32'd1);
    chk("race_data", 32'(tx_data), 32'h79);

    // Asynchronous reset mid-packet, then lane 0 has priority again
    do_reset();
    req_valid = 4'b0100;
    req_data  = 32'h0022_0020;
    req_last  = 4'b0101;
    tick();
    chk("rstmid_txr_before", 32'(tx_ready), 32'd1);
    cpu_resetn = 1'b0;
    #1;
    chk("rstmid_txr", 32'(tx_ready), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_grant", 32'(grant), 32'd0);
    tick();
    cpu_resetn = 1'b1;
    req_valid  = 4'b0101;
    #1;
    chk("rstmid_ready", 32'(req_ready), 32'b0001);
    tick();
    chk("rstmid_data", 32'(tx_data), 32'h20);
    chk("rstmid_grant_after", 32'(grant), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
